// File: rtl/m3_pkg.sv
// Shared constants and state codes for the m3 speed controller family.
// Period limits are shared with the period calculator.
package m3_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ACCEL     = 3'd1,
      ST_CRUISE    = 3'd2,
      ST_DECEL     = 3'd3,
      ST_STOPPING  = 3'd4,
      ST_REVERSING = 3'd5,
      ST_FAULT     = 3'd6
   } state_e;

   localparam int M3_PERIOD_MAX_SYN = 4000000;
   localparam int M3_PERIOD_MAX_SIM = 300;
   localparam int M3_PERIOD_MIN     = 40;
   localparam int M3_STALL_CYC_SYN  = 8000000;
   localparam int M3_STALL_CYC_SIM  = 700;

   // Regulation window half-width is tgt >> WIN_SHIFT (6.25 %).
   localparam int WIN_SHIFT = 4;

endpackage

// File: rtl/m3_stall_timer.sv
// Saturating cycle counter; flags a stall once STALL_CYC cycles pass
// with the enable high and no clear.
module m3_stall_timer
   import m3_pkg::*;
#(
   parameter int STALL_W   = 24,
   parameter int STALL_CYC = M3_STALL_CYC_SYN
) (
   input  logic clkI,
   input  logic rstI,
   input  logic enI,
   input  logic clrI,
   output logic stallO
);

   localparam logic [STALL_W-1:0] LIMIT = STALL_W'(STALL_CYC);

   logic [STALL_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clrI) begin
         cnt_d = '0;
      end else if (enI && (cnt_q < LIMIT)) begin
         cnt_d = cnt_q + STALL_W'(1);
      end
   end

   always_ff @(posedge clkI or posedge rstI) begin
      if (rstI) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stallO = (cnt_q >= LIMIT);

endmodule

// File: rtl/m3_ramp_sequencer.sv
// Run/ramp controller for the m3 period calculator: start, regulation,
// controlled stop, reversal through standstill, force stop and stall fault.
module m3_ramp_sequencer
   import m3_pkg::*;
#(
   parameter int LEN_W      = 32,
   parameter int PERIOD_MAX = M3_PERIOD_MAX_SYN,
   parameter int PERIOD_MIN = M3_PERIOD_MIN,
   parameter int STALL_CYC  = M3_STALL_CYC_SYN,
   parameter int STALL_W    = 24
) (
   input  logic             clkI,
   input  logic             rstI,
   input  logic             runI,
   input  logic             dirI,
   input  logic             stopI,
   input  logic [LEN_W-1:0] targetLenI,
   input  logic [LEN_W-1:0] curLenI,
   input  logic             roundDoneI,
   output logic             workingO,
   output logic             nextRoundO,
   output logic             speedIncO,
   output logic             speedDecO,
   output logic             invRotateO,
   output logic             forceStopO,
   output logic             faultO,
   output logic [2:0]       stateO
);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PERIOD_MAX);
   localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(PERIOD_MIN);

   state_e           state_q, state_d;
   logic             working_q, working_d;
   logic             next_round_q, next_round_d;
   logic             inc_q, inc_d;
   logic             dec_q, dec_d;
   logic             inv_q, inv_d;
   logic             force_q, force_d;
   logic             fault_q, fault_d;
   logic [LEN_W-1:0] tgt_q, tgt_d, tgt_clamped;
   logic [LEN_W:0]   win_hi, win_lo, cur_ext;
   logic             slow, fast, at_max, stall;

   m3_stall_timer #(
      .STALL_W   (STALL_W),
      .STALL_CYC (STALL_CYC)
   ) u_stall (
      .clkI   (clkI),
      .rstI   (rstI),
      .enI    (working_q),
      .clrI   (roundDoneI | ~working_q),
      .stallO (stall)
   );

   always_comb begin
      tgt_clamped = targetLenI;
      if (targetLenI < LEN_MIN) begin
         tgt_clamped = LEN_MIN;
      end else if (targetLenI > LEN_MAX) begin
         tgt_clamped = LEN_MAX;
      end
      tgt_d = (roundDoneI || (state_q == ST_IDLE)) ? tgt_clamped : tgt_q;
   end

   // One extra bit keeps tgt + tgt/16 from wrapping at large periods.
   assign cur_ext = {1'b0, curLenI};
   assign win_hi  = {1'b0, tgt_q} + ({1'b0, tgt_q} >> WIN_SHIFT);
   assign win_lo  = {1'b0, tgt_q} - ({1'b0, tgt_q} >> WIN_SHIFT);
   assign slow    = cur_ext > win_hi;
   assign fast    = cur_ext < win_lo;
   assign at_max  = curLenI >= LEN_MAX;

   always_comb begin
      state_d = state_q;
      inv_d   = inv_q;
      if (state_q == ST_FAULT) begin
         if (!stopI && !runI) state_d = ST_IDLE;
      end else if (stopI || stall) begin
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (runI) begin
                  inv_d   = dirI;
                  state_d = ST_ACCEL;
               end
            end
            ST_ACCEL, ST_CRUISE, ST_DECEL: begin
               if (!runI)                state_d = ST_STOPPING;
               else if (dirI != inv_q)   state_d = ST_REVERSING;
               else if (state_q == ST_ACCEL) begin
                  if (!slow) state_d = ST_CRUISE;
               end else if (state_q == ST_DECEL) begin
                  if (!fast) state_d = ST_CRUISE;
               end else if (slow)        state_d = ST_ACCEL;
               else if (fast)            state_d = ST_DECEL;
            end
            ST_STOPPING: begin
               if (!runI) begin
                  if (at_max) state_d = ST_IDLE;
               end else if (dirI != inv_q) state_d = ST_REVERSING;
               else                        state_d = ST_ACCEL;
            end
            ST_REVERSING: begin
               if (!runI)              state_d = ST_STOPPING;
               else if (dirI == inv_q) state_d = ST_CRUISE;
               else if (at_max) begin
                  inv_d   = ~inv_q;
                  state_d = ST_ACCEL;
               end
            end
            default: state_d = ST_FAULT;
         endcase
      end

      // Outputs follow the next state so they change together with stateO.
      working_d    = state_d inside {ST_ACCEL, ST_CRUISE, ST_DECEL, ST_STOPPING, ST_REVERSING};
      inc_d        = (state_d == ST_ACCEL);
      dec_d        = state_d inside {ST_DECEL, ST_STOPPING, ST_REVERSING};
      force_d      = (state_d == ST_FAULT);
      fault_d      = (state_d == ST_FAULT);
      next_round_d = roundDoneI & working_q & working_d;
   end

   always_ff @(posedge clkI or posedge rstI) begin
      if (rstI) begin
         state_q      <= ST_IDLE;
         working_q    <= 1'b0;
         next_round_q <= 1'b0;
         inc_q        <= 1'b0;
         dec_q        <= 1'b0;
         inv_q        <= 1'b0;
         force_q      <= 1'b0;
         fault_q      <= 1'b0;
         tgt_q        <= LEN_MAX;
      end else begin
         state_q      <= state_d;
         working_q    <= working_d;
         next_round_q <= next_round_d;
         inc_q        <= inc_d;
         dec_q        <= dec_d;
         inv_q        <= inv_d;
         force_q      <= force_d;
         fault_q      <= fault_d;
         tgt_q        <= tgt_d;
      end
   end

   assign workingO   = working_q;
   assign nextRoundO = next_round_q;
   assign speedIncO  = inc_q;
   assign speedDecO  = dec_q;
   assign invRotateO = inv_q;
   assign forceStopO = force_q;
   assign faultO     = fault_q;
   assign stateO     = state_q;

   a_inc_dec_excl: assert property (@(posedge clkI) disable iff (rstI) !(inc_q && dec_q));

endmodule

// File: tb/tb_m3_ramp_sequencer.sv
// Directed bench for m3_ramp_sequencer: table of per-cycle vectors plus
// hand-written stall and asynchronous-reset sequences.
module tb_m3_ramp_sequencer;

   logic        clkI = 1'b0;
   logic        rstI;
   logic        runI, dirI, stopI, roundDoneI;
   logic [31:0] targetLenI, curLenI;
   logic        workingO, nextRoundO, speedIncO, speedDecO;
   logic        invRotateO, forceStopO, faultO;
   logic [2:0]  stateO;

   typedef struct packed {
      logic [2:0] st;
      logic       wk, nr, inc, dec, inv, fs, flt;
   } outs_t;

   typedef struct {
      logic        run, dir, stop, rd;
      logic [31:0] tgt, cur;
      outs_t       exp;
   } vec_t;

   vec_t vecs[$];
   int   checkCount = 0;
   int   errCount   = 0;

   m3_ramp_sequencer #(
      .LEN_W      (32),
      .PERIOD_MAX (300),
      .PERIOD_MIN (40),
      .STALL_CYC  (700),
      .STALL_W    (24)
   ) dut (
      .clkI       (clkI),
      .rstI       (rstI),
      .runI       (runI),
      .dirI       (dirI),
      .stopI      (stopI),
      .targetLenI (targetLenI),
      .curLenI    (curLenI),
      .roundDoneI (roundDoneI),
      .workingO   (workingO),
      .nextRoundO (nextRoundO),
      .speedIncO  (speedIncO),
      .speedDecO  (speedDecO),
      .invRotateO (invRotateO),
      .forceStopO (forceStopO),
      .faultO     (faultO),
      .stateO     (stateO)
   );

   always #5 clkI = ~clkI;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic addVec(input logic run, input logic dir, input logic stop,
                         input logic [31:0] tgt, input logic [31:0] cur, input logic rd,
                         input logic [2:0] st, input logic wk, input logic nr,
                         input logic inc, input logic dec, input logic inv,
                         input logic fs, input logic flt);
      vec_t v;
      v.run = run; v.dir = dir; v.stop = stop; v.tgt = tgt; v.cur = cur; v.rd = rd;
      v.exp = '{st: st, wk: wk, nr: nr, inc: inc, dec: dec, inv: inv, fs: fs, flt: flt};
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clkI);
      runI       = v.run;
      dirI       = v.dir;
      stopI      = v.stop;
      targetLenI = v.tgt;
      curLenI    = v.cur;
      roundDoneI = v.rd;
      @(posedge clkI);
      #1;
   endtask

   task automatic checkOutput(input string name, input outs_t exp);
      outs_t act;
      act = {stateO, workingO, nextRoundO, speedIncO, speedDecO, invRotateO, forceStopO, faultO};
      checkCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got st=%0d wk/nr/inc/dec/inv/fs/flt=%b, expected st=%0d wk/nr/inc/dec/inv/fs/flt=%b",
                  name, act.st, act[6:0], exp.st, exp[6:0]);
      end
   endtask

   task automatic checkValue(input string name, input int act, input int lo, input int hi);
      checkCount++;
      if (act < lo || act > hi) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   initial begin
      vec_t v;
      int   n;

      //     run dir stp tgt           cur  rd   st wk nr in de iv fs fl
      addVec(0, 0, 0, 100,          300, 0,  0, 0, 0, 0, 0, 0, 0, 0);
      addVec(1, 0, 0, 100,          300, 0,  1, 1, 0, 1, 0, 0, 0, 0);
      addVec(1, 0, 0, 100,          300, 1,  1, 1, 1, 1, 0, 0, 0, 0);
      addVec(1, 0, 0, 100,          200, 0,  1, 1, 0, 1, 0, 0, 0, 0);
      addVec(1, 0, 0, 100,          106, 0,  2, 1, 0, 0, 0, 0, 0, 0);
      addVec(1, 0, 0, 100,          100, 0,  2, 1, 0, 0, 0, 0, 0, 0);
      addVec(1, 0, 0, 100,           93, 0,  3, 1, 0, 0, 1, 0, 0, 0);
      addVec(1, 0, 0, 100,           94, 0,  2, 1, 0, 0, 0, 0, 0, 0);
      addVec(1, 0, 0, 250,          100, 0,  2, 1, 0, 0, 0, 0, 0, 0);
      addVec(1, 0, 0, 250,          100, 1,  2, 1, 1, 0, 0, 0, 0, 0);
      addVec(1, 0, 0, 250,          100, 0,  3, 1, 0, 0, 1, 0, 0, 0);
      addVec(1, 0, 0, 250,          200, 0,  3, 1, 0, 0, 1, 0, 0, 0);
      addVec(1, 0, 0, 250,          234, 0,  3, 1, 0, 0, 1, 0, 0, 0);
      addVec(1, 0, 0, 250,          235, 0,  2, 1, 0, 0, 0, 0, 0, 0);
      addVec(0, 0, 0, 250,          100, 0,  4, 1, 0, 0, 1, 0, 0, 0);
      addVec(0, 0, 0, 250,          200, 0,  4, 1, 0, 0, 1, 0, 0, 0);
      addVec(0, 0, 0, 250,          300, 1,  0, 0, 0, 0, 0, 0, 0, 0);
      addVec(1, 0, 0, 250,          300, 0,  1, 1, 0, 1, 0, 0, 0, 0);
      addVec(1, 0, 0, 250,          250, 0,  2, 1, 0, 0, 0, 0, 0, 0);
      addVec(1, 1, 0, 250,          250, 0,  5, 1, 0, 0, 1, 0, 0, 0);
      addVec(1, 1, 0, 250,          299, 0,  5, 1, 0, 0, 1, 0, 0, 0);
      addVec(1, 1, 0, 250,          300, 0,  1, 1, 0, 1, 0, 1, 0, 0);
      addVec(1, 1, 0, 250,          300, 0,  1, 1, 0, 1, 0, 1, 0, 0);
      addVec(1, 1, 0, 250,          250, 0,  2, 1, 0, 0, 0, 1, 0, 0);
      addVec(1, 0, 0, 250,          250, 0,  5, 1, 0, 0, 1, 1, 0, 0);
      addVec(1, 1, 0, 250,          260, 0,  2, 1, 0, 0, 0, 1, 0, 0);
      addVec(0, 1, 0, 250,          260, 0,  4, 1, 0, 0, 1, 1, 0, 0);
      addVec(1, 1, 0, 250,          270, 0,  1, 1, 0, 1, 0, 1, 0, 0);
      addVec(1, 1, 1, 250,          270, 0,  6, 0, 0, 0, 0, 1, 1, 1);
      addVec(1, 1, 0, 250,          270, 0,  6, 0, 0, 0, 0, 1, 1, 1);
      addVec(0, 1, 0, 250,          270, 0,  0, 0, 0, 0, 0, 1, 0, 0);
      addVec(0, 0, 0, 10,           300, 0,  0, 0, 0, 0, 0, 1, 0, 0);
      addVec(1, 0, 0, 10,           300, 0,  1, 1, 0, 1, 0, 0, 0, 0);
      addVec(1, 0, 0, 10,            42, 0,  2, 1, 0, 0, 0, 0, 0, 0);
      addVec(1, 0, 0, 10,            37, 0,  3, 1, 0, 0, 1, 0, 0, 0);
      addVec(1, 0, 0, 10,            38, 0,  2, 1, 0, 0, 0, 0, 0, 0);
      addVec(1, 0, 0, 32'hFFFFFFFF,  38, 1,  2, 1, 1, 0, 0, 0, 0, 0);
      addVec(1, 0, 0, 32'hFFFFFFFF, 290, 0,  2, 1, 0, 0, 0, 0, 0, 0);
      addVec(1, 0, 0, 32'hFFFFFFFF, 281, 0,  3, 1, 0, 0, 1, 0, 0, 0);
      addVec(1, 0, 0, 32'hFFFFFFFF, 319, 0,  2, 1, 0, 0, 0, 0, 0, 0);
      addVec(1, 0, 0, 32'hFFFFFFFF, 319, 0,  1, 1, 0, 1, 0, 0, 0, 0);
      addVec(1, 0, 0, 32'hFFFFFFFF, 318, 0,  2, 1, 0, 0, 0, 0, 0, 0);

      rstI = 1'b1;
      runI = 1'b0; dirI = 1'b0; stopI = 1'b0; roundDoneI = 1'b0;
      targetLenI = 32'd100; curLenI = 32'd300;
      repeat (2) @(posedge clkI);
      #1;
      checkOutput("reset", '0);
      @(negedge clkI);
      rstI = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      end

      $display("[TB] stall sequence");
      v.run = 1; v.dir = 0; v.stop = 0; v.tgt = 300; v.cur = 300; v.rd = 1;
      applyStimulus(v);
      checkOutput("stall_start", '{st: 3'd2, wk: 1, nr: 1, inc: 0, dec: 0, inv: 0, fs: 0, flt: 0});
      roundDoneI = 1'b0;
      n = 0;
      while (stateO != 3'd6 && n < 1000) begin
         @(posedge clkI);
         #1;
         n++;
      end
      checkValue("stall_cycles", n, 700, 702);
      checkOutput("stall_fault", '{st: 3'd6, wk: 0, nr: 0, inc: 0, dec: 0, inv: 0, fs: 1, flt: 1});
      v.run = 0; v.rd = 0;
      applyStimulus(v);
      checkOutput("stall_exit", '0);

      $display("[TB] reset during reversal");
      v.run = 1; v.dir = 0; v.tgt = 250; v.cur = 300;
      applyStimulus(v);
      checkOutput("rev_start", '{st: 3'd1, wk: 1, nr: 0, inc: 1, dec: 0, inv: 0, fs: 0, flt: 0});
      v.dir = 1; v.cur = 200;
      applyStimulus(v);
      checkOutput("rev_enter", '{st: 3'd5, wk: 1, nr: 0, inc: 0, dec: 1, inv: 0, fs: 0, flt: 0});
      @(negedge clkI);
      #2;
      rstI = 1'b1;
      #1;
      checkOutput("async_reset", '0);
      @(negedge clkI);
      rstI = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
      $finish;
   end

endmodule
